mesi_isc_broad_queue: RTL

Broadcast request queue feeding `mesi_isc_broad_cntl`. It accepts snoop broadcast entries from the main-bus request arbiter and stores them in order. It presents the oldest entry with first-word-fall-through (show-ahead) semantics, together with empty and full status. The broadcast controller pops an entry once all CPU acks for it are collected.

---
 rtl/mesi_isc_pkg.sv | 31 +++
 rtl/mesi_isc_broad_queue_if.sv | 39 +++
 rtl/mesi_isc_basic_fifo.sv | 68 ++++++
 rtl/mesi_isc_broad_queue.sv | 67 ++++++
 4 files changed

// File: rtl/mesi_isc_pkg.sv
// Shared definitions for the MESI intersection controller: bus widths,
// broadcast/cbus encodings and the broadcast queue entry layout.
package mesi_isc_pkg;

    localparam int ADDR_WIDTH       = 32;
    localparam int BROAD_TYPE_WIDTH = 2;
    localparam int BROAD_ID_WIDTH   = 5;
    localparam int CBUS_CMD_WIDTH   = 3;

    localparam logic [BROAD_TYPE_WIDTH-1:0] BROAD_NOP = 2'd0;
    localparam logic [BROAD_TYPE_WIDTH-1:0] BROAD_WR  = 2'd1;
    localparam logic [BROAD_TYPE_WIDTH-1:0] BROAD_RD  = 2'd2;

    localparam logic [CBUS_CMD_WIDTH-1:0] CBUS_CMD_NOP      = 3'd0;
    localparam logic [CBUS_CMD_WIDTH-1:0] CBUS_CMD_WR_SNOOP = 3'd1;
    localparam logic [CBUS_CMD_WIDTH-1:0] CBUS_CMD_RD_SNOOP = 3'd2;
    localparam logic [CBUS_CMD_WIDTH-1:0] CBUS_CMD_EN_WR    = 3'd3;
    localparam logic [CBUS_CMD_WIDTH-1:0] CBUS_CMD_EN_RD    = 3'd4;

    typedef struct packed {
        logic [ADDR_WIDTH-1:0]       addr;
        logic [BROAD_TYPE_WIDTH-1:0] btype;
        logic [1:0]                  cpu_id;
        logic [BROAD_ID_WIDTH-1:0]   id;
    } broad_entry_t;

    function automatic logic broad_is_nop(input logic [BROAD_TYPE_WIDTH-1:0] btype);
        return btype == BROAD_NOP;
    endfunction

endpackage

// File: rtl/mesi_isc_broad_queue_if.sv
// Arbiter/controller-facing signals of the broadcast queue.
interface mesi_isc_broad_queue_if
    import mesi_isc_pkg::*;
#(
    parameter int AW  = ADDR_WIDTH,
    parameter int TW  = BROAD_TYPE_WIDTH,
    parameter int IW  = BROAD_ID_WIDTH
) ();
    logic          broad_wr_i;
    logic [AW-1:0] broad_addr_i;
    logic [TW-1:0] broad_type_i;
    logic [1:0]    broad_cpu_id_i;
    logic [IW-1:0] broad_id_i;
    logic          broad_fifo_rd_i;
    logic [AW-1:0] broad_snoop_addr_o;
    logic [TW-1:0] broad_snoop_type_o;
    logic [1:0]    broad_snoop_cpu_id_o;
    logic [IW-1:0] broad_snoop_id_o;
    logic          fifo_status_empty_o;
    logic          fifo_status_full_o;
    logic          fifo_status_almost_full_o;
    logic          broad_err_o;

    modport master (
        output broad_wr_i, broad_addr_i, broad_type_i, broad_cpu_id_i, broad_id_i,
               broad_fifo_rd_i,
        input  broad_snoop_addr_o, broad_snoop_type_o, broad_snoop_cpu_id_o,
               broad_snoop_id_o, fifo_status_empty_o, fifo_status_full_o,
               fifo_status_almost_full_o, broad_err_o
    );

    modport slave (
        input  broad_wr_i, broad_addr_i, broad_type_i, broad_cpu_id_i, broad_id_i,
               broad_fifo_rd_i,
        output broad_snoop_addr_o, broad_snoop_type_o, broad_snoop_cpu_id_o,
               broad_snoop_id_o, fifo_status_empty_o, fifo_status_full_o,
               fifo_status_almost_full_o, broad_err_o
    );
endinterface

// File: rtl/mesi_isc_basic_fifo.sv
// Generic synchronous show-ahead FIFO; callers must only assert wr_en/rd_en
// when the operation is legal.
module mesi_isc_basic_fifo #(
    parameter int WIDTH      = 8,
    parameter int DEPTH_LOG2 = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             rd_en,
    output logic [WIDTH-1:0] rd_data,
    output logic             empty,
    output logic             full,
    output logic             almost_full
);
    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam int CNT_W = DEPTH_LOG2 + 1;

    logic [WIDTH-1:0]      mem [DEPTH];
    logic [DEPTH_LOG2-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]      count_q, count_d;
    logic                  empty_q, empty_d, full_q, full_d, af_q, af_d;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (wr_en) wr_ptr_d = wr_ptr_q + 1'b1;
        if (rd_en) rd_ptr_d = rd_ptr_q + 1'b1;
        case ({wr_en, rd_en})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
        // Flags track the next count so they are valid together with the new head.
        empty_d = (count_d == '0);
        full_d  = (count_d == CNT_W'(DEPTH));
        af_d    = (count_d >= CNT_W'(DEPTH - 1));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            empty_q  <= 1'b1;
            full_q   <= 1'b0;
            af_q     <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            empty_q  <= empty_d;
            full_q   <= full_d;
            af_q     <= af_d;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en && !rst) mem[wr_ptr_q] <= wr_data;
    end

    assign rd_data     = mem[rd_ptr_q];
    assign empty       = empty_q;
    assign full        = full_q;
    assign almost_full = af_q;
endmodule

// File: rtl/mesi_isc_broad_queue.sv
// Broadcast request queue between the main-bus arbiter and mesi_isc_broad_cntl:
// NOP filtering, full+pop push admission, zero-masked head and sticky error.
module mesi_isc_broad_queue #(
    parameter int ADDR_WIDTH       = 32,
    parameter int BROAD_TYPE_WIDTH = 2,
    parameter int BROAD_ID_WIDTH   = 5,
    parameter int DEPTH_LOG2       = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    mesi_isc_broad_queue_if.slave q_if
);
    import mesi_isc_pkg::*;

    typedef struct packed {
        logic [ADDR_WIDTH-1:0]       addr;
        logic [BROAD_TYPE_WIDTH-1:0] btype;
        logic [1:0]                  cpu_id;
        logic [BROAD_ID_WIDTH-1:0]   id;
    } entry_t;

    entry_t wr_entry, rd_entry;
    logic   push_req, push_ok, pop_ok;
    logic   empty, full, almost_full;
    logic   err_q, err_d;

    always_comb begin
        push_req = q_if.broad_wr_i && (q_if.broad_type_i != BROAD_NOP);
        pop_ok   = q_if.broad_fifo_rd_i && !empty;
        push_ok  = push_req && (!full || pop_ok);
        // Overflow and underflow both latch; an underflowing pop never blocks a push.
        err_d    = err_q | (push_req && !push_ok) | (q_if.broad_fifo_rd_i && empty);
        wr_entry = '{addr:   q_if.broad_addr_i,
                     btype:  q_if.broad_type_i,
                     cpu_id: q_if.broad_cpu_id_i,
                     id:     q_if.broad_id_i};
    end

    mesi_isc_basic_fifo #(
        .WIDTH      ($bits(entry_t)),
        .DEPTH_LOG2 (DEPTH_LOG2)
    ) u_fifo (
        .clk         (clk),
        .rst         (rst),
        .wr_en       (push_ok),
        .wr_data     (wr_entry),
        .rd_en       (pop_ok),
        .rd_data     (rd_entry),
        .empty       (empty),
        .full        (full),
        .almost_full (almost_full)
    );

    always_ff @(posedge clk) begin
        if (rst) err_q <= 1'b0;
        else     err_q <= err_d;
    end

    assign q_if.broad_snoop_addr_o        = empty ? '0 : rd_entry.addr;
    assign q_if.broad_snoop_type_o        = empty ? '0 : rd_entry.btype;
    assign q_if.broad_snoop_cpu_id_o      = empty ? '0 : rd_entry.cpu_id;
    assign q_if.broad_snoop_id_o          = empty ? '0 : rd_entry.id;
    assign q_if.fifo_status_empty_o       = empty;
    assign q_if.fifo_status_full_o        = full;
    assign q_if.fifo_status_almost_full_o = almost_full;
    assign q_if.broad_err_o               = err_q;
endmodule
